// File: rtl/bus_mux_arb.sv
// N-to-1 valid/ready multiplexer with round-robin or fixed-priority arbitration,
// an optional manual channel override, and a one-word registered output stage.
module bus_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int RR    = 1,
  localparam int CW   = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 sel_en,
  input  logic [CW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_ch,
  output logic [15:0]          xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic [CW-1:0] cand;
  logic          grant_vld;
  logic          load_ok;
  logic          take;

  // Round-robin search walks downward so the nearest channel after last_grant
  // is the final (winning) assignment.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (sel_en) begin
      if (int'(sel) < NCH) begin
        grant     = sel;
        grant_vld = in_valid[sel];
      end
    end else if (RR != 0) begin
      for (int k = NCH; k >= 1; k--) begin
        cand = CW'((int'(last_grant) + k) % NCH);
        if (in_valid[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant     = CW'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_ok  = (state == EMPTY) || out_ready;
    take     = load_ok && grant_vld;
    state_nx = state;
    if (load_ok) state_nx = take ? FULL : EMPTY;
    in_ready = '0;
    if (take && !rst) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // Output register, transfer counter and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_ch     <= '0;
      xfer_cnt   <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      if (state == FULL && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
      if (take) begin
        out_data   <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_ch     <= grant;
        last_grant <= grant;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_bus_mux_arb.sv
// Randomized and directed bench for bus_mux_arb: a 4-channel round-robin DUT and a
// 5-channel fixed-priority DUT share control inputs and are compared against a model.
module tb_bus_mux_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_en;
  logic        out_ready;

  logic [31:0] in_data_a;
  logic [3:0]  in_valid_a, in_ready_a;
  logic [1:0]  sel_a, out_ch_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic [15:0] xfer_cnt_a;

  logic [39:0] in_data_b;
  logic [4:0]  in_valid_b, in_ready_b;
  logic [2:0]  sel_b, out_ch_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic [15:0] xfer_cnt_b;

  int ncmp;
  int nfail;

  typedef struct {
    bit full;
    int data;
    int ch;
    int last;
    int cnt;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  bus_mux_arb #(.WIDTH(8), .NCH(4), .RR(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .sel_en(sel_en), .sel(sel_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_ch(out_ch_a),
    .xfer_cnt(xfer_cnt_a)
  );

  bus_mux_arb #(.WIDTH(8), .NCH(5), .RR(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sel_en(sel_en), .sel(sel_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ch(out_ch_b),
    .xfer_cnt(xfer_cnt_b)
  );

  function automatic mdl_t mreset(input int nch);
    mdl_t r;
    r.full = 1'b0; r.data = 0; r.ch = 0; r.last = nch - 1; r.cnt = 0;
    return r;
  endfunction

  // Granted channel index, or -1 when nobody may be served.
  function automatic int mgrant(input mdl_t m, input int nch, input int rr,
                                input logic [15:0] v, input bit sen, input int s);
    if (sen) return (s < nch && v[s]) ? s : -1;
    if (rr != 0) begin
      for (int k = 1; k <= nch; k++)
        if (v[(m.last + k) % nch]) return (m.last + k) % nch;
    end else begin
      for (int i = 0; i < nch; i++)
        if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int mready(input mdl_t m, input int nch, input int rr,
                                input logic [15:0] v, input bit sen, input int s,
                                input bit ordy);
    int g;
    g = mgrant(m, nch, rr, v, sen, s);
    if ((!m.full || ordy) && g >= 0) return 1 << g;
    return 0;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int nch, input int rr,
                                 input logic [15:0] v, input logic [127:0] d,
                                 input bit sen, input int s, input bit ordy);
    mdl_t r;
    int g;
    r = m;
    g = mgrant(m, nch, rr, v, sen, s);
    if (m.full && ordy) r.cnt = (m.cnt + 1) % 65536;
    if (!m.full || ordy) begin
      if (g >= 0) begin
        r.full = 1'b1; r.data = int'(d[g*8 +: 8]); r.ch = g; r.last = g;
      end else begin
        r.full = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] va, input logic vb4, input logic sen,
                               input logic [1:0] sa, input logic [2:0] sb,
                               input logic ordy);
    in_valid_a = va;
    in_valid_b = {vb4, va};
    sel_en     = sen;
    sel_a      = sa;
    sel_b      = sb;
    out_ready  = ordy;
    in_data_a  = $urandom;
    in_data_b  = {8'($urandom), in_data_a};
  endtask

  task automatic checkOutput();
    int ea, eb;
    ea = rst ? 0 : mready(ma, 4, 1, 16'(in_valid_a), sel_en, int'(sel_a), out_ready);
    eb = rst ? 0 : mready(mb, 5, 0, 16'(in_valid_b), sel_en, int'(sel_b), out_ready);
    cmp("a_in_ready",  32'(in_ready_a),  32'(ea));
    cmp("a_out_valid", 32'(out_valid_a), 32'(ma.full));
    cmp("a_out_data",  32'(out_data_a),  32'(ma.data));
    cmp("a_out_ch",    32'(out_ch_a),    32'(ma.ch));
    cmp("a_xfer_cnt",  32'(xfer_cnt_a),  32'(ma.cnt));
    cmp("b_in_ready",  32'(in_ready_b),  32'(eb));
    cmp("b_out_valid", 32'(out_valid_b), 32'(mb.full));
    cmp("b_out_data",  32'(out_data_b),  32'(mb.data));
    cmp("b_out_ch",    32'(out_ch_b),    32'(mb.ch));
    cmp("b_xfer_cnt",  32'(xfer_cnt_b),  32'(mb.cnt));
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic runCycle(input bit chk);
    if (chk) begin
      @(negedge clk);
      checkOutput();
    end
    @(posedge clk);
    if (rst) begin
      ma = mreset(4);
      mb = mreset(5);
    end else begin
      ma = mstep(ma, 4, 1, 16'(in_valid_a), 128'(in_data_a), sel_en, int'(sel_a), out_ready);
      mb = mstep(mb, 5, 0, 16'(in_valid_b), 128'(in_data_b), sel_en, int'(sel_b), out_ready);
    end
    #1;
  endtask

  initial begin
    int c0;
    int guard;
    ncmp  = 0;
    nfail = 0;
    rst   = 1'b0;
    ma    = mreset(4);
    mb    = mreset(5);

    $display("[TB] reset phase");
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b1);
    #1 rst = 1'b1;
    runCycle(1);
    runCycle(1);
    rst = 1'b0;

    $display("[TB] round-robin rotation");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
      runCycle(1);
      cmp("a_rr_seq", 32'(out_ch_a), 32'(i % 4));
    end
    cmp("a_cnt8", 32'(xfer_cnt_a), 32'd8);

    $display("[TB] fixed priority");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1110, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
      runCycle(1);
      cmp("b_fixed_ch", 32'(out_ch_b), 32'd1);
      cmp("b_no_rdy23", 32'(in_ready_b[3:2]), 32'd0);
    end

    $display("[TB] backpressure");
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    runCycle(1);
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    in_data_a[7:0] = 8'hA5;
    in_data_b      = {in_data_b[39:32], in_data_a};
    runCycle(1);
    c0 = ma.cnt;
    for (int i = 0; i < 5; i++) begin
      runCycle(1);
      cmp("a_hold_data",  32'(out_data_a),  32'h0000_00A5);
      cmp("a_hold_valid", 32'(out_valid_a), 32'd1);
      cmp("a_hold_ready", 32'(in_ready_a),  32'd0);
      cmp("a_hold_cnt",   32'(xfer_cnt_a),  32'(c0));
    end

    $display("[TB] manual select");
    applyStimulus(4'b1111, 1'b1, 1'b1, 2'd2, 3'd5, 1'b1);
    runCycle(1);
    runCycle(1);
    cmp("a_sel_ready", 32'(in_ready_a),  32'b0100);
    cmp("a_sel_ch",    32'(out_ch_a),    32'd2);
    cmp("b_sel_ready", 32'(in_ready_b),  32'd0);
    cmp("b_sel_drop",  32'(out_valid_b), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom), 1'($urandom), ($urandom % 4) == 0,
                    2'($urandom), 3'($urandom), ($urandom % 3) != 0);
      runCycle(1);
    end

    $display("[TB] async reset while full");
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    runCycle(1);
    runCycle(1);
    #2 rst = 1'b1;
    #1;
    ma = mreset(4);
    mb = mreset(5);
    cmp("a_rst_valid", 32'(out_valid_a), 32'd0);
    cmp("a_rst_cnt",   32'(xfer_cnt_a),  32'd0);
    cmp("a_rst_ready", 32'(in_ready_a),  32'd0);
    cmp("b_rst_valid", 32'(out_valid_b), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, 3'd0, 1'b1);
    runCycle(1);
    cmp("a_first_grant", 32'(out_ch_a), 32'd0);
    cmp("b_first_grant", 32'(out_ch_b), 32'd0);

    $display("[TB] counter wrap");
    applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
    guard = 0;
    while (ma.cnt != 65535 && guard < 70000) begin
      runCycle(0);
      guard++;
    end
    checkOutput();
    cmp("a_cnt_ffff", 32'(xfer_cnt_a), 32'h0000_FFFF);
    runCycle(1);
    cmp("a_cnt_wrap", 32'(xfer_cnt_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
